// File: rtl/shift_register.sv
// Parallel-input delay line for the polyphase FIR datapath: each accepted batch of
// PARALLELISM samples shifts the MEM_LEN-slot history window toward slot 0.
module shift_register #(
  parameter int N           = 21,
  parameter int NB          = 18,
  parameter int PARALLELISM = 8
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic                                i_enable,
  input  logic                                i_valid,
  input  logic [PARALLELISM*NB-1:0]           i_data,
  output logic [(N+PARALLELISM-1)*NB-1:0]     o_data
);

  localparam int MEM_LEN = N + PARALLELISM - 1;
  // Slots below KEEP are refilled from older history; the top PARALLELISM take the batch.
  localparam int KEEP    = MEM_LEN - PARALLELISM;

  // Handshake: a batch is accepted on every rising edge where i_enable && i_valid
  // and i_reset is low. There is no ready; the line never back-pressures.
  logic          shift;
  logic [NB-1:0] mem [MEM_LEN];
  logic [NB-1:0] nxt [MEM_LEN];

  assign shift = i_enable && i_valid;

  for (genvar k = 0; k < MEM_LEN; k++) begin : g_slot
    if (k < KEEP) begin : g_old
      assign nxt[k] = mem[k+PARALLELISM];
    end else begin : g_new
      assign nxt[k] = i_data[(k-KEEP)*NB +: NB];
    end
    assign o_data[k*NB +: NB] = mem[k];
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int k = 0; k < MEM_LEN; k++) mem[k] <= '0;
    end else if (shift) begin
      for (int k = 0; k < MEM_LEN; k++) mem[k] <= nxt[k];
    end
  end

endmodule

// File: tb/tb_shift_register.sv
// Directed bench for shift_register: a sample-history queue model feeds an expected
// window queue checked every cycle, plus hand-computed slot values from the plan.
module tb_shift_register;

  localparam int N  = 21;
  localparam int NB = 18;
  localparam int P  = 8;
  localparam int ML = N + P - 1;
  localparam int W  = ML * NB;

  logic            clk;
  logic            i_reset;
  logic            i_enable;
  logic            i_valid;
  logic [P*NB-1:0] i_data;
  logic [W-1:0]    o_data;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]    exp_q[$];
  logic [NB-1:0]   hist[$];
  bit              model_live = 0;

  shift_register #(.N(N), .NB(NB), .PARALLELISM(P)) dut (
    .i_clock  (clk),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .o_data   (o_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [P*NB-1:0] mk_batch(input int s);
    logic [P*NB-1:0] b;
    b = '0;
    for (int j = 0; j < P; j++) b[j*NB +: NB] = NB'(s + j);
    return b;
  endfunction

  // Model: the window is simply the last ML samples accepted since reset, zero-padded.
  task automatic model_step(input logic r, input logic e, input logic v,
                            input logic [P*NB-1:0] d);
    logic [W-1:0] w;
    if (r) begin
      hist.delete();
      for (int k = 0; k < ML; k++) hist.push_back('0);
      model_live = 1;
    end else if (e && v && model_live) begin
      for (int j = 0; j < P; j++) begin
        hist.push_back(d[j*NB +: NB]);
        void'(hist.pop_front());
      end
    end
    if (model_live) begin
      w = '0;
      for (int k = 0; k < ML; k++) w[k*NB +: NB] = hist[hist.size()-ML+k];
      exp_q.push_back(w);
    end
  endtask

  // driver: inputs change on the falling edge, model advances just after the rising edge
  task automatic drive(input logic r, input logic e, input logic v,
                       input logic [P*NB-1:0] d);
    @(negedge clk);
    i_reset  = r;
    i_enable = e;
    i_valid  = v;
    i_data   = d;
    @(posedge clk);
    #1;
    model_step(r, e, v, d);
  endtask

  // scoreboard: whole window against the model once per cycle
  always @(negedge clk) begin
    logic [W-1:0] exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      total++;
      if (o_data !== exp) begin
        bad++;
        $display("FAIL window got=%h exp=%h", o_data, exp);
      end
    end
  end

  task automatic check_slot(input string name, input int k, input int val);
    logic [NB-1:0] got;
    got = o_data[k*NB +: NB];
    total++;
    if (got !== NB'(val)) begin
      bad++;
      $display("FAIL %s slot%0d got=%0d exp=%0d", name, k, got, val);
    end
  endtask

  initial begin
    logic [P*NB-1:0] ones;
    ones     = '1;
    i_reset  = 1'b0;
    i_enable = 1'b0;
    i_valid  = 1'b0;
    i_data   = '0;

    drive(1, 0, 0, ones);
    for (int k = 0; k < ML; k++) check_slot("reset", k, 0);

    drive(0, 1, 0, ones);
    check_slot("gate_valid", 0, 0);
    check_slot("gate_valid", ML-1, 0);
    drive(0, 0, 1, ones);
    check_slot("gate_enable", 0, 0);
    check_slot("gate_enable", ML-1, 0);

    drive(0, 1, 1, mk_batch(1));
    check_slot("b1", 19, 0);
    check_slot("b1", 20, 1);
    check_slot("b1", 27, 8);

    drive(0, 1, 1, mk_batch(9));
    check_slot("b2", 11, 0);
    check_slot("b2", 12, 1);
    check_slot("b2", 19, 8);
    check_slot("b2", 20, 9);
    check_slot("b2", 27, 16);

    drive(0, 1, 1, mk_batch(17));
    drive(0, 1, 1, mk_batch(25));
    for (int k = 0; k < ML; k++) check_slot("full", k, k + 5);
    check_slot("fir0_first", 0, 5);
    check_slot("fir0_last", 20, 25);
    check_slot("fir7_first", 7, 12);
    check_slot("fir7_last", 27, 32);

    // hold with garbage on the bus, then resume with a bubble in between
    drive(0, 0, 0, ones);
    check_slot("hold", 27, 32);
    drive(0, 1, 1, mk_batch(100));
    drive(0, 1, 0, mk_batch(200));
    drive(0, 1, 1, mk_batch(300));
    check_slot("resume", 27, 307);
    check_slot("resume", 19, 107);
    check_slot("resume", 0, 21);

    drive(1, 0, 0, '0);
    for (int k = 0; k < ML; k++) check_slot("mid_reset", k, 0);

    drive(0, 1, 1, mk_batch(40));
    drive(1, 1, 1, mk_batch(50));
    for (int k = 0; k < ML; k++) check_slot("reset_wins", k, 0);

    drive(0, 1, 1, mk_batch(60));
    check_slot("after_reset", 19, 0);
    check_slot("after_reset", 20, 60);

    drive(0, 0, 0, '0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
